// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch stage that owns the fetch PC and issues in-order I-cache requests.
// Returned instructions are buffered in a DEPTH-entry queue that feeds decode.
// Credits (outstanding + buffered < DEPTH) bound the number of requests in flight. A redirect
// flushes the queue and discards responses that are still in flight.
//
// Optional build macro: FETCH_BYPASS_EN. When it is defined, a response that arrives while the
// queue is empty and decode is ready goes straight to dec_* in the same cycle.
//
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   redirect, redirect_pc            flush and restart fetch at redirect_pc
//   ic_req, ic_req_pc, ic_ready      I-cache request handshake (ic_req is combinational)
//   ic_resp_v, ic_resp_pc,
//   ic_resp_inst                     in-order I-cache responses
//   dec_v, dec_pc, dec_inst,
//   dec_ready                        queue head towards decode
module fetch_queue_unit #(
  parameter int unsigned     ADDR       = 32,
  parameter int unsigned     INST       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [ADDR-1:0] RESET_PC   = '0,
  parameter int unsigned     FETCH_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            ic_req,
  output logic [ADDR-1:0] ic_req_pc,
  input  logic            ic_ready,
  input  logic            ic_resp_v,
  input  logic [ADDR-1:0] ic_resp_pc,
  input  logic [INST-1:0] ic_resp_inst,
  output logic            dec_v,
  output logic [ADDR-1:0] dec_pc,
  output logic [INST-1:0] dec_inst,
  input  logic            dec_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 1;

  logic [ADDR-1:0] pc_q, pc_n;
  logic [PW-1:0]   head_q, head_n, tail_q, tail_n;
  logic [CW-1:0]   count_q, count_n, out_q, out_n, drop_q, drop_n;
  logic [ADDR-1:0] pc_mem   [DEPTH];
  logic [INST-1:0] inst_mem [DEPTH];

  logic            empty, accept, resp_drop, bypass_take, push, q_pop;
  logic [SW-1:0]   credit_sum;

  // Handshake decode and the head-of-queue view presented to decode
  always_comb begin
    empty       = (count_q == '0);
    credit_sum  = SW'(out_q) + SW'(count_q);
    // Gated by reset so no request is presented while the block is held in reset
    ic_req      = !reset && !redirect && (credit_sum < SW'(DEPTH));
    ic_req_pc   = pc_q;
    accept      = ic_req && ic_ready;
    resp_drop   = ic_resp_v && (drop_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass_take = empty && ic_resp_v && (drop_q == '0) && dec_ready && !redirect;
    dec_v       = !empty || bypass_take;
    dec_pc      = bypass_take ? ic_resp_pc   : pc_mem[head_q];
    dec_inst    = bypass_take ? ic_resp_inst : inst_mem[head_q];
`else
    bypass_take = 1'b0;
    dec_v       = !empty;
    dec_pc      = pc_mem[head_q];
    dec_inst    = inst_mem[head_q];
`endif
    // A redirect wipes the queue, so it suppresses any same-cycle push or pop
    push        = ic_resp_v && !resp_drop && !bypass_take && !redirect;
    q_pop       = !empty && dec_ready && !redirect;
  end

  // Next-state for PC, credits, drop counter and queue pointers
  always_comb begin
    pc_n    = pc_q;
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    out_n   = out_q + CW'(accept) - CW'(ic_resp_v);
    drop_n  = drop_q - CW'(resp_drop);

    if (accept) pc_n = pc_q + ADDR'(FETCH_STEP);
    if (push)   tail_n = tail_q + PW'(1);
    if (q_pop)  head_n = head_q + PW'(1);
    count_n = count_q + CW'(push) - CW'(q_pop);

    if (redirect) begin
      // out_n already excludes a same-cycle response, and that response is discarded
      pc_n    = redirect_pc;
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
      drop_n  = drop_n + out_n;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      out_q   <= out_n;
      drop_q  <= drop_n;
    end
  end

  // Queue storage; cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[tail_q]   <= ic_resp_pc;
      inst_mem[tail_q] <= ic_resp_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (DEPTH=4, RESET_PC=0x100).
// A small I-cache model answers accepted requests in order, starting at the earliest one cycle
// after acceptance. Inputs change on the falling edge, and outputs are sampled 1 time unit later.
module tb_fetch_queue_unit;

  localparam logic [31:0] MAGIC = 32'hDEAD_0000;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic [31:0] ic_req_pc;
  logic        ic_ready;
  logic        ic_resp_v;
  logic [31:0] ic_resp_pc;
  logic [31:0] ic_resp_inst;
  logic        dec_v;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_ready;

  // Values applied at the next falling edge
  logic        s_redirect, s_ic_ready, s_dec_ready, resp_en;
  logic [31:0] s_redirect_pc;
  logic [31:0] pending[$];
  int          acc_cnt;
  int          n_vec, n_miss;
  int          lat;

  fetch_queue_unit #(
    .ADDR(32), .INST(32), .DEPTH(4), .RESET_PC(32'h100), .FETCH_STEP(4)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ic_req(ic_req), .ic_req_pc(ic_req_pc), .ic_ready(ic_ready),
    .ic_resp_v(ic_resp_v), .ic_resp_pc(ic_resp_pc), .ic_resp_inst(ic_resp_inst),
    .dec_v(dec_v), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, let them settle, then update the I-cache model
  task automatic tick();
    @(negedge clk);
    redirect    = s_redirect;
    redirect_pc = s_redirect_pc;
    ic_ready    = s_ic_ready;
    dec_ready   = s_dec_ready;
    if (resp_en && pending.size() > 0) begin
      ic_resp_v    = 1'b1;
      ic_resp_pc   = pending[0];
      ic_resp_inst = pending[0] ^ MAGIC;
    end else begin
      ic_resp_v    = 1'b0;
      ic_resp_pc   = '0;
      ic_resp_inst = '0;
    end
    #1;
    if (ic_resp_v) void'(pending.pop_front());
    if (ic_req && ic_ready) begin
      pending.push_back(ic_req_pc);
      acc_cnt++;
    end
  endtask

  // Tick until dec_v shows, with a bound; returns the number of ticks taken
  task automatic wait_dec(output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n++;
      if (dec_v) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0; ic_ready = 1'b0; ic_resp_v = 1'b0; dec_ready = 1'b0;
    s_redirect = 1'b0; s_redirect_pc = '0; s_ic_ready = 1'b0; s_dec_ready = 1'b0;
    resp_en = 1'b0;
    pending.delete();
    acc_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; acc_cnt = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; ic_ready = 1'b0;
    ic_resp_v = 1'b0; ic_resp_pc = '0; ic_resp_inst = '0; dec_ready = 1'b0;
    s_redirect = 1'b0; s_redirect_pc = '0; s_ic_ready = 1'b0; s_dec_ready = 1'b0;
    resp_en = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_ic_req", 32'(ic_req), 32'd0);
    check("rst_ic_req_pc", ic_req_pc, 32'h100);
    check("rst_dec_v", 32'(dec_v), 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_inst", dec_inst, 32'h0);

    // Streaming: one decoded PC per cycle once the pipeline fills
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b1; resp_en = 1'b1;
    wait_dec(lat);
    check("t1_latency", 32'(lat), 32'(3 - BYP));
    check("t1_pc0", dec_pc, 32'h100);
    check("t1_inst0", dec_inst, 32'h100 ^ MAGIC);
    for (int i = 1; i < 6; i++) begin
      tick();
      check("t1_v", 32'(dec_v), 32'd1);
      check("t1_pc", dec_pc, 32'h100 + 32'(4 * i));
    end

    // Back-pressure: the credits allow exactly DEPTH requests
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b0; resp_en = 1'b1;
    repeat (6) tick();
    check("t2_req_stall", 32'(ic_req), 32'd0);
    check("t2_accepted", 32'(acc_cnt), 32'd4);
    check("t2_head", dec_pc, 32'h100);
    s_dec_ready = 1'b1;
    tick();
    check("t2_req_pop_cyc", 32'(ic_req), 32'd0);
    s_dec_ready = 1'b0;
    tick();
    check("t2_req_resume", 32'(ic_req), 32'd1);
    check("t2_req_pc", ic_req_pc, 32'h110);
    check("t2_head_after_pop", dec_pc, 32'h104);
    // Reset mid-operation takes effect immediately
    reset = 1'b1; #1;
    check("t2_mid_rst_dec_v", 32'(dec_v), 32'd0);
    check("t2_mid_rst_req", 32'(ic_req), 32'd0);
    check("t2_mid_rst_pc", ic_req_pc, 32'h100);

    // Redirect with two requests in flight: both responses are dropped
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b1; resp_en = 1'b0;
    s_redirect = 1'b1; s_redirect_pc = 32'h200;
    tick();
    check("t3_req_redir0", 32'(ic_req), 32'd0);
    s_redirect = 1'b0;
    tick();
    check("t3_req_pc0", ic_req_pc, 32'h200);
    tick();
    check("t3_req_pc1", ic_req_pc, 32'h204);
    s_redirect = 1'b1; s_redirect_pc = 32'h800;
    tick();
    check("t3_req_redir", 32'(ic_req), 32'd0);
    s_redirect = 1'b0; resp_en = 1'b1;
    wait_dec(lat);
    check("t3_latency", 32'(lat), 32'(4 - BYP));
    check("t3_first_pc", dec_pc, 32'h800);
    tick();
    check("t3_second_pc", dec_pc, 32'h804);

    // Redirect in the same cycle as a response and a pop
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    resp_en = 1'b1;
    tick();
    check("t4_req_4th", 32'(ic_req), 32'd1);
    s_dec_ready = 1'b1; s_redirect = 1'b1; s_redirect_pc = 32'h400;
    tick();
    check("t4_req_redir", 32'(ic_req), 32'd0);
    check("t4_dec_v_redir", 32'(dec_v), 32'd1);
    s_redirect = 1'b0;
    tick();
    check("t4_flushed", 32'(dec_v), 32'd0);
    wait_dec(lat);
    check("t4_latency", 32'(lat), 32'(3 - BYP));
    check("t4_first_pc", dec_pc, 32'h400);
    tick();
    check("t4_second_pc", dec_pc, 32'h404);

    // PC wraps at the top of the address space
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b0; resp_en = 1'b1;
    s_redirect = 1'b1; s_redirect_pc = 32'hFFFF_FFFC;
    tick();
    s_redirect = 1'b0;
    tick();
    check("t5_req_top", ic_req_pc, 32'hFFFF_FFFC);
    tick();
    check("t5_req_wrap", ic_req_pc, 32'h0);
    tick();
    check("t5_dec_top", dec_pc, 32'hFFFF_FFFC);
    s_dec_ready = 1'b1;
    tick();
    tick();
    check("t5_dec_wrap", dec_pc, 32'h0);

    // Response into an empty queue: same-cycle only with the bypass built in
    do_reset();
    s_ic_ready = 1'b1; s_dec_ready = 1'b1; resp_en = 1'b0;
    tick();
    resp_en = 1'b1;
    tick();
    check("t6_same_cyc_v", 32'(dec_v), 32'(BYP));
    tick();
    check("t6_next_v", 32'(dec_v), 32'd1);
    check("t6_next_pc", dec_pc, (BYP == 1) ? 32'h104 : 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
